// File: rtl/d_cache_pkg.sv
// d_cache_pkg: shared state enum and default geometry for the write-back data cache
package d_cache_pkg;
  localparam int DEF_ENTRIES = 8;
  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 64;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
endpackage

// File: rtl/d_cache_array.sv
// d_cache_array: valid/dirty/tag/data storage, one combinational read port and one write port
module d_cache_array #(
  parameter int ENTRIES = 8,
  parameter int TAG_W = 27,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(ENTRIES)-1:0] idx_i,
  input  logic                       we_i,
  input  logic [TAG_W-1:0]           wtag_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       wdirty_i,
  output logic                       valid_o,
  output logic                       dirty_o,
  output logic [TAG_W-1:0]           tag_o,
  output logic [DATA_W-1:0]          data_o
);
  logic [ENTRIES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [DATA_W-1:0] data_q [ENTRIES];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o = tag_q[idx_i];
  assign data_o = data_q[idx_i];
  // line status flags; cleared by reset so every line starts invalid and clean
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= wdirty_i;
    end
  end
  // tag and data payload; never cleared, validity is tracked by the flags
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[idx_i] <= wtag_i;
      data_q[idx_i] <= wdata_i;
    end
  end
endmodule

// File: rtl/d_cache_wb.sv
// d_cache_wb: direct-mapped write-back data cache with miss FSM (IDLE/WRITEBACK/ALLOCATE)
module d_cache_wb
  import d_cache_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag, c_tag;
  logic [DATA_W-1:0] c_data;
  logic c_valid, c_dirty, hit, req, fill, whit;
  assign idx = proc_addr[IDX_W-1:0];
  assign tag = proc_addr[ADDR_W-1:IDX_W];
  assign hit = c_valid && (c_tag == tag);
  assign req = proc_read || proc_write;
  assign fill = (state_q == ALLOCATE) && mem_ready;
  assign whit = (state_q == IDLE) && proc_write && hit;
  d_cache_array #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_array (
    .clk(clk),
    .rst_n(rst_n),
    .idx_i(idx),
    .we_i(fill || whit),
    .wtag_i(tag),
    .wdata_i(fill ? mem_rdata : proc_wdata),
    .wdirty_i(!fill),
    .valid_o(c_valid),
    .dirty_o(c_dirty),
    .tag_o(c_tag),
    .data_o(c_data)
  );
  // miss-handling state register; reset abandons any in-flight request
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state and state-decoded memory/CPU outputs
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE && req && !hit) ? (c_valid && c_dirty ? WRITEBACK : ALLOCATE)
            : (state_q == WRITEBACK && mem_ready) ? ALLOCATE
            : (state_q == ALLOCATE && mem_ready) ? IDLE : state_q;
    mem_write = state_q == WRITEBACK;
    mem_read = state_q == ALLOCATE;
    mem_addr = (state_q == WRITEBACK) ? {c_tag, idx} : (state_q == ALLOCATE) ? proc_addr : '0;
    mem_wdata = (state_q == WRITEBACK) ? c_data : '0;
    proc_stall = (state_q != IDLE) || (req && !hit);
    proc_rdata = (state_q == IDLE && proc_read && hit) ? c_data : '0;
  end
endmodule

// File: tb/tb_d_cache_wb.sv
// tb_d_cache_wb: table-driven cycle vectors plus bounded hand sequences for d_cache_wb
module tb_d_cache_wb;
  logic clk = 1'b0, rst_n = 1'b0, proc_read = 1'b0, proc_write = 1'b0, mem_ready = 1'b0;
  logic [29:0] proc_addr = '0;
  logic [63:0] proc_wdata = '0, mem_rdata = '0;
  logic [63:0] proc_rdata, mem_wdata;
  logic [29:0] mem_addr;
  logic proc_stall, mem_read, mem_write;
  int errors = 0, checks = 0;

  typedef struct {
    logic rn, rd, wr;
    logic [29:0] a;
    logic [63:0] wd, md;
    logic mr;
    logic st;
    logic [63:0] rdat;
    logic mrd, mwr;
    logic [29:0] ma;
    logic [63:0] mwd;
  } vec_t;
  vec_t vecs[$];

  d_cache_wb dut (
    .clk(clk), .rst_n(rst_n), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rn, logic rd, logic wr, logic [29:0] a, logic [63:0] wd,
                              logic [63:0] md, logic mr, logic st, logic [63:0] rdat,
                              logic mrd, logic mwr, logic [29:0] ma, logic [63:0] mwd);
    vec_t v;
    v.rn = rn; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.md = md; v.mr = mr;
    v.st = st; v.rdat = rdat; v.mrd = mrd; v.mwr = mwr; v.ma = ma; v.mwd = mwd;
    return v;
  endfunction

  task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst, rd, wr, addr, wdata, mrdata, mready | stall, rdata, mread, mwrite, maddr, mwdata
    vecs.push_back(mk(1,0,0,'h00,0,0,0,       0,0,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h10,0,0,0,       1,0,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h10,0,0,0,       1,0,1,0,'h10,0));
    vecs.push_back(mk(1,1,0,'h10,0,0,0,       1,0,1,0,'h10,0));
    vecs.push_back(mk(1,1,0,'h10,0,'hAAAA,1,  1,0,1,0,'h10,0));
    vecs.push_back(mk(1,1,0,'h10,0,0,0,       0,'hAAAA,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h10,0,0,0,       0,'hAAAA,0,0,'h00,0));
    vecs.push_back(mk(1,0,1,'h10,'h1234,0,0,  0,0,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h18,0,0,0,       1,0,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h18,0,0,0,       1,0,0,1,'h10,'h1234));
    vecs.push_back(mk(1,1,0,'h18,0,0,1,       1,0,0,1,'h10,'h1234));
    vecs.push_back(mk(1,1,0,'h18,0,0,0,       1,0,1,0,'h18,0));
    vecs.push_back(mk(1,1,0,'h18,0,'hBEEF,1,  1,0,1,0,'h18,0));
    vecs.push_back(mk(1,1,0,'h18,0,0,0,       0,'hBEEF,0,0,'h00,0));
    vecs.push_back(mk(1,0,1,'h21,'h5555,0,0,  1,0,0,0,'h00,0));
    vecs.push_back(mk(1,0,1,'h21,'h5555,0,1,  1,0,1,0,'h21,0));
    vecs.push_back(mk(1,0,1,'h21,'h5555,0,0,  0,0,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h21,0,0,0,       0,'h5555,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h29,0,0,0,       1,0,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h29,0,0,1,       1,0,0,1,'h21,'h5555));
    vecs.push_back(mk(1,1,0,'h29,0,'h77,1,    1,0,1,0,'h29,0));
    vecs.push_back(mk(1,1,0,'h29,0,0,0,       0,'h77,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h30,0,0,0,       1,0,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h30,0,0,0,       1,0,1,0,'h30,0));
    vecs.push_back(mk(0,1,0,'h30,0,0,0,       1,0,1,0,'h30,0));
    vecs.push_back(mk(1,1,0,'h30,0,0,0,       1,0,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h30,0,'h99,1,    1,0,1,0,'h30,0));
    vecs.push_back(mk(1,1,0,'h30,0,0,0,       0,'h99,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h29,0,0,0,       1,0,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h29,0,'h77,1,    1,0,1,0,'h29,0));
    vecs.push_back(mk(1,1,0,'h29,0,0,0,       0,'h77,0,0,'h00,0));
    vecs.push_back(mk(1,0,0,'h00,0,'hDEAD,1,  0,0,0,0,'h00,0));
    vecs.push_back(mk(1,1,0,'h29,0,0,0,       0,'h77,0,0,'h00,0));

    rst_n = 1'b0;
    tick();
    tick();
    foreach (vecs[i]) begin
      rst_n = vecs[i].rn; proc_read = vecs[i].rd; proc_write = vecs[i].wr;
      proc_addr = vecs[i].a; proc_wdata = vecs[i].wd; mem_rdata = vecs[i].md; mem_ready = vecs[i].mr;
      #1;
      chk($sformatf("vec%0d", i),
          {31'b0, proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata},
          {31'b0, vecs[i].st, vecs[i].rdat, vecs[i].mrd, vecs[i].mwr, vecs[i].ma, vecs[i].mwd});
      tick();
    end

    // clean miss on 0x41 evicts clean 0x29: bounded wait for the line read
    rst_n = 1'b1; proc_read = 1'b1; proc_write = 1'b0; proc_addr = 'h41; mem_ready = 1'b0;
    #1;
    chk("miss41_stall", proc_stall, 1);
    begin
      int n = 0;
      while (!mem_read && n < 10) begin
        chk("miss41_no_wb", mem_write, 0);
        tick();
        n++;
      end
    end
    chk("miss41_mread", mem_read, 1);
    chk("miss41_maddr", mem_addr, 'h41);
    tick();
    tick();
    mem_rdata = 'h4141; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_rdata = '0;
    #1;
    chk("hit41_stall", proc_stall, 0);
    chk("hit41_rdata", proc_rdata, 'h4141);
    chk("hit41_idle", {mem_read, mem_write}, 0);
    proc_addr = 'h29;
    #1;
    chk("evicted29_miss", proc_stall, 1);
    proc_read = 1'b0;
    #1;
    chk("noreq_stall", proc_stall, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
